// File: rtl/wm8731_i2c_config.sv
// WM8731 codec configuration master: walks an 11-entry register table over I2C
// after reset or on request, or rewrites only the headphone-volume entries.
module wm8731_i2c_config #(
  parameter int         CLK_FREQ    = 50000000,
  parameter int         I2C_FREQ    = 100000,
  parameter logic [7:0] DEV_ADDR    = 8'h34,
  parameter int         MAX_RETRY   = 3,
  parameter int         POWERUP_DLY = 16
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iSTART,
  input  logic       iVOL_UPD,
  input  logic [6:0] iVOL,
  output logic       oI2C_SCLK,
  inout  wire        ioI2C_SDAT,
  output logic       oBUSY,
  output logic       oDONE,
  output logic       oERR
);

  localparam int Q  = CLK_FREQ / (4 * I2C_FREQ);
  localparam int QW = (Q > 1) ? $clog2(Q) : 1;
  localparam int PW = (POWERUP_DLY > 1) ? $clog2(POWERUP_DLY) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [QW-1:0] Q_LAST    = QW'(Q - 1);
  localparam logic [PW-1:0] PWR_LAST  = PW'(POWERUP_DLY - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE, WAIT_PWR, START, SHIFT, STOP, CHECK, GAP, FINISH
  } state_t;

  state_t        state, stateNext;
  logic [QW-1:0] qCnt;
  logic [1:0]    phase;
  logic [4:0]    bitIdx;
  logic [3:0]    entry, lastEntry;
  logic [RW-1:0] retryCnt;
  logic [PW-1:0] pwrCnt;
  logic          nackSeen;
  logic          sdaSync;
  logic [26:0]   shReg;
  logic [6:0]    volReg;
  logic [15:0]   wordNow;
  logic          tick, ackSlot, scl, sdaLow;
  logic          runStart, runFull, entryDone, retryNow, giveUp, finishRun;

  function automatic logic [15:0] tableWord(input logic [3:0] idx, input logic [6:0] vol);
    logic [15:0] w;
    case (idx)
      4'd0:    w = 16'h1E00;
      4'd1:    w = 16'h001A;
      4'd2:    w = 16'h021A;
      4'd3:    w = {7'h02, 2'b00, vol};
      4'd4:    w = {7'h03, 2'b00, vol};
      4'd5:    w = 16'h08F8;
      4'd6:    w = 16'h0A06;
      4'd7:    w = 16'h0C00;
      4'd8:    w = 16'h0E01;
      4'd9:    w = 16'h1002;
      4'd10:   w = 16'h1201;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  assign tick    = (qCnt == Q_LAST);
  assign ackSlot = (bitIdx == 5'd8) || (bitIdx == 5'd17) || (bitIdx == 5'd26);
  assign wordNow = tableWord(entry, volReg);

  assign oI2C_SCLK  = scl;
  assign ioI2C_SDAT = sdaLow ? 1'b0 : 1'bz;

  always_comb begin
    stateNext = state;
    scl       = 1'b1;
    sdaLow    = 1'b0;
    runStart  = 1'b0;
    runFull   = 1'b0;
    entryDone = 1'b0;
    retryNow  = 1'b0;
    giveUp    = 1'b0;
    finishRun = 1'b0;
    case (state)
      IDLE: begin
        if (iSTART || iVOL_UPD) begin
          runStart  = 1'b1;
          runFull   = iSTART;
          stateNext = START;
        end
      end
      WAIT_PWR: begin
        if (tick && pwrCnt == PWR_LAST) begin
          runStart  = 1'b1;
          runFull   = 1'b1;
          stateNext = START;
        end
      end
      START: begin
        // one idle quarter, then SDA low for 2Q with SCL still high
        sdaLow = (phase != 2'd0);
        if (tick && phase == 2'd2) stateNext = SHIFT;
      end
      SHIFT: begin
        scl    = phase[1];
        sdaLow = ~shReg[26];
        if (tick && phase == 2'd3 && bitIdx == 5'd26) stateNext = STOP;
      end
      STOP: begin
        scl    = phase[1];
        sdaLow = 1'b1;
        if (tick && phase == 2'd3) stateNext = CHECK;
      end
      CHECK: begin
        if (!nackSeen) begin
          entryDone = 1'b1;
          stateNext = GAP;
        end else if (retryCnt != RETRY_MAX) begin
          retryNow  = 1'b1;
          stateNext = GAP;
        end else begin
          giveUp    = 1'b1;
          stateNext = IDLE;
        end
      end
      GAP: begin
        if (tick && phase == 2'd3) stateNext = (entry > lastEntry) ? FINISH : START;
      end
      FINISH: begin
        finishRun = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= WAIT_PWR;
    else         state <= stateNext;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      qCnt      <= '0;
      phase     <= 2'd0;
      bitIdx    <= 5'd0;
      entry     <= 4'd0;
      lastEntry <= 4'd0;
      retryCnt  <= '0;
      pwrCnt    <= '0;
      nackSeen  <= 1'b0;
      oBUSY     <= 1'b0;
      oDONE     <= 1'b0;
      oERR      <= 1'b0;
    end else begin
      // tick counter restarts with every run so the first START edge lands Q clocks later
      qCnt <= (state == IDLE || tick) ? '0 : qCnt + QW'(1);

      if (stateNext != state) phase <= 2'd0;
      else if (tick)          phase <= phase + 2'd1;

      if (state == START)                             bitIdx <= 5'd0;
      else if (state == SHIFT && tick && phase == 2'd3) bitIdx <= bitIdx + 5'd1;

      if (state == WAIT_PWR && tick) pwrCnt <= pwrCnt + PW'(1);

      if (state == START) nackSeen <= 1'b0;
      else if (state == SHIFT && tick && phase == 2'd2 && ackSlot && sdaSync) nackSeen <= 1'b1;

      if (runStart) begin
        entry     <= runFull ? 4'd0 : 4'd3;
        lastEntry <= runFull ? 4'd10 : 4'd4;
        retryCnt  <= '0;
        oBUSY     <= 1'b1;
        oDONE     <= 1'b0;
        oERR      <= 1'b0;
      end
      if (entryDone) begin
        entry    <= entry + 4'd1;
        retryCnt <= '0;
      end
      if (retryNow) retryCnt <= retryCnt + RW'(1);
      if (giveUp) begin
        oBUSY <= 1'b0;
        oERR  <= 1'b1;
      end
      if (finishRun) begin
        oBUSY <= 1'b0;
        oDONE <= 1'b1;
      end
    end
  end

  // Frame shifter: address, reg/data bytes, with released slots for the three ACKs
  always_ff @(posedge iCLK) begin
    sdaSync <= ioI2C_SDAT;
    if (runStart) volReg <= iVOL;
    if (state == START && tick && phase == 2'd2)
      shReg <= {DEV_ADDR, 1'b1, wordNow[15:8], 1'b1, wordNow[7:0], 1'b1};
    else if (state == SHIFT && tick && phase == 2'd3)
      shReg <= {shReg[25:0], 1'b1};
  end

endmodule

// File: tb/tb_wm8731_i2c_config.sv
// Directed bench for wm8731_i2c_config with an ACKing I2C slave model that
// records every written frame and measures SCL high/low periods.
module tb_wm8731_i2c_config;

  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       iSTART = 1'b0;
  logic       iVOL_UPD = 1'b0;
  logic [6:0] iVOL = 7'h79;
  wire        sclBus;
  wire        sdaBus;
  logic       busy, done, err;
  logic       slaveLow = 1'b0;

  pullup (sdaBus);
  assign sdaBus = slaveLow ? 1'b0 : 1'bz;

  wm8731_i2c_config #(
    .CLK_FREQ(160000), .I2C_FREQ(10000), .DEV_ADDR(8'h34), .MAX_RETRY(3), .POWERUP_DLY(16)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iSTART(iSTART), .iVOL_UPD(iVOL_UPD), .iVOL(iVOL),
    .oI2C_SCLK(sclBus), .ioI2C_SDAT(sdaBus), .oBUSY(busy), .oDONE(done), .oERR(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // slave model state
  logic [23:0] txQ[$];
  logic        clrReq = 1'b0;
  int          nackMode = 0;
  int          nacksGiven = 0;
  logic        sclPrev = 1'b1, sdaPrev = 1'b1, inTrans = 1'b0, ackPhase = 1'b0;
  logic [7:0]  shiftIn = 8'h00;
  logic [23:0] frame = 24'h0;
  int          slvBitCnt = 0, byteCnt = 0;
  int          startCnt = 0, stopCnt = 0, badStart = 0, badTime = 0, timeMeas = 0;
  int          cyc = 0, lastFall = -1, lastRise = -1;

  always @(negedge clk) begin : slave
    logic s, d, nack;
    s = sclBus;
    d = sdaBus;
    if (clrReq) begin
      txQ.delete();
      startCnt = 0; stopCnt = 0; badStart = 0; badTime = 0; timeMeas = 0;
      inTrans = 1'b0; ackPhase = 1'b0; slaveLow = 1'b0; nacksGiven = 0;
    end else if (s && sclPrev && sdaPrev && !d) begin
      if (inTrans) badStart++;
      startCnt++;
      inTrans = 1'b1; ackPhase = 1'b0; slvBitCnt = 0; byteCnt = 0; frame = 24'h0;
      lastFall = -1; lastRise = -1;
    end else if (s && sclPrev && !sdaPrev && d) begin
      stopCnt++;
      if (inTrans) txQ.push_back(frame);
      inTrans = 1'b0;
    end else if (inTrans) begin
      if (s && !sclPrev) begin
        if (lastFall >= 0) begin
          timeMeas++;
          if (cyc - lastFall != 2 * Q) badTime++;
        end
        lastRise = cyc;
        if (!ackPhase) begin
          shiftIn = {shiftIn[6:0], d};
          slvBitCnt++;
        end
      end else if (!s && sclPrev) begin
        if (lastRise >= 0) begin
          timeMeas++;
          if (cyc - lastRise != 2 * Q) badTime++;
        end
        lastFall = cyc;
        if (ackPhase) begin
          slaveLow = 1'b0;
          ackPhase = 1'b0;
        end else if (slvBitCnt == 8) begin
          frame = {frame[15:0], shiftIn};
          byteCnt++;
          slvBitCnt = 0;
          ackPhase = 1'b1;
          nack = (byteCnt == 2) && (shiftIn == 8'h08) &&
                 (nackMode == 2 || (nackMode == 1 && nacksGiven == 0));
          if (nack) nacksGiven++;
          slaveLow = !nack;
        end
      end
    end
    sclPrev = s;
    sdaPrev = d;
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic s, input logic v);
    @(negedge clk);
    iSTART = s;
    iVOL_UPD = v;
    @(negedge clk);
    iSTART = 1'b0;
    iVOL_UPD = 1'b0;
  endtask

  task automatic clearStats();
    @(posedge clk);
    clrReq = 1'b1;
    @(posedge clk);
    clrReq = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 20000), 32'd1);
  endtask

  task automatic waitBusyRise(output int n);
    n = 0;
    while (!busy && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  logic [23:0] expFull[11] = '{24'h341E00, 24'h34001A, 24'h34021A, 24'h340479, 24'h340679,
                               24'h3408F8, 24'h340A06, 24'h340C00, 24'h340E01, 24'h341002,
                               24'h341201};

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_scl", 32'(sclBus), 32'd1);
    check("rst_sda", 32'(sdaBus), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // power-up auto run
    waitBusyRise(n);
    check("pwr_delay", n, 32'd64);
    n = 0;
    while (sdaBus && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("first_start_edge", n, Q);
    check("start_scl_high", 32'(sclBus), 32'd1);
    waitIdle("pwr_run");
    check("pwr_done", 32'(done), 32'd1);
    check("pwr_err", 32'(err), 32'd0);
    check("pwr_txcount", txQ.size(), 32'd11);
    for (int i = 0; i < 11; i++) check($sformatf("pwr_tx%0d", i), 32'(txQ[i]), 32'(expFull[i]));
    check("pwr_starts", startCnt, 32'd11);
    check("pwr_stops", stopCnt, 32'd11);
    check("pwr_badstart", badStart, 32'd0);
    check("pwr_sclperiod_bad", badTime, 32'd0);
    check("pwr_sclperiod_meas", timeMeas, 32'd605);
    check("pwr_idle_sda", 32'(sdaBus), 32'd1);

    // single NACK on entry 5
    clearStats();
    nackMode = 1;
    pulse(1'b1, 1'b0);
    check("nack1_busy", 32'(busy), 32'd1);
    check("nack1_done_clr", 32'(done), 32'd0);
    waitIdle("nack1_run");
    check("nack1_done", 32'(done), 32'd1);
    check("nack1_err", 32'(err), 32'd0);
    check("nack1_txcount", txQ.size(), 32'd12);
    check("nack1_tx5", 32'(txQ[5]), 32'h3408F8);
    check("nack1_tx6", 32'(txQ[6]), 32'h3408F8);
    check("nack1_tx7", 32'(txQ[7]), 32'h340A06);
    check("nack1_tx11", 32'(txQ[11]), 32'h341201);

    // permanent NACK on entry 5
    clearStats();
    nackMode = 2;
    pulse(1'b1, 1'b0);
    waitIdle("nackall_run");
    check("nackall_err", 32'(err), 32'd1);
    check("nackall_done", 32'(done), 32'd0);
    repeat (500) @(posedge clk);
    #1;
    check("nackall_txcount", txQ.size(), 32'd9);
    for (int i = 5; i < 9; i++) check($sformatf("nackall_tx%0d", i), 32'(txQ[i]), 32'h3408F8);
    check("nackall_sda", 32'(sdaBus), 32'd1);
    check("nackall_scl", 32'(sclBus), 32'd1);
    check("nackall_busy", 32'(busy), 32'd0);

    // volume-only update, iVOL changed mid-run
    clearStats();
    nackMode = 0;
    iVOL = 7'h30;
    pulse(1'b0, 1'b1);
    check("vol_busy", 32'(busy), 32'd1);
    check("vol_err_clr", 32'(err), 32'd0);
    repeat (20) @(posedge clk);
    iVOL = 7'h55;
    waitIdle("vol_run");
    check("vol_done", 32'(done), 32'd1);
    check("vol_txcount", txQ.size(), 32'd2);
    check("vol_tx0", 32'(txQ[0]), 32'h340430);
    check("vol_tx1", 32'(txQ[1]), 32'h340630);

    // start while busy is ignored
    clearStats();
    pulse(1'b1, 1'b0);
    repeat (50) @(posedge clk);
    pulse(1'b1, 1'b1);
    waitIdle("busy_run");
    repeat (100) @(posedge clk);
    #1;
    check("busy_idle", 32'(busy), 32'd0);
    check("busy_txcount", txQ.size(), 32'd11);
    check("busy_tx3", 32'(txQ[3]), 32'h340455);

    // reset in the middle of the address byte
    clearStats();
    pulse(1'b1, 1'b0);
    n = 0;
    while (!(slvBitCnt == 3 && !sclBus && !slaveLow && inTrans) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reached", 32'(n < 5000), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_scl", 32'(sclBus), 32'd1);
    check("midrst_sda", 32'(sdaBus), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    clearStats();
    @(negedge clk);
    rst_n = 1'b1;
    waitBusyRise(n);
    check("midrst_pwr_delay", n, 32'd64);
    waitIdle("midrst_run");
    check("midrst_done", 32'(done), 32'd1);
    check("midrst_txcount", txQ.size(), 32'd11);
    check("midrst_tx0", 32'(txQ[0]), 32'h341E00);

    // simultaneous start and volume pulses
    clearStats();
    pulse(1'b1, 1'b1);
    waitIdle("both_run");
    check("both_done", 32'(done), 32'd1);
    check("both_txcount", txQ.size(), 32'd11);
    check("both_tx0", 32'(txQ[0]), 32'h341E00);
    check("both_tx10", 32'(txQ[10]), 32'h341201);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
